// File: rtl/hex_capture_monitor.sv
// hex_capture_monitor
//   Watches a soft core's debug PC and its 7-segment display buses. After an
//   arm request it counts RUN cycles until the program-end PC appears, then
//   snapshots the segment buses, decodes each channel to a hex digit and
//   reports pass/fail. RUN also ends on a cycle timeout or, if enabled, on a
//   stalled PC.
//
//   Build option: define HEXMON_STALL_EN to enable stall detection. Without
//   it there is no stall counter and o_stall is tied to 0.
//
//   Ports
//     i_clk        clock, rising edge
//     i_reset      asynchronous active-low reset
//     i_arm        start request, sampled in IDLE
//     i_clear      synchronous return to IDLE, clears all results
//     i_pc         core debug PC
//     i_hex        packed active-low segment buses, channel k at [7k+6:7k]
//     o_state      0 IDLE, 1 RUN, 2 CAPTURE, 3 DONE
//     o_done       high while in DONE
//     o_pass       end PC reached and every channel decoded cleanly
//     o_timeout    RUN exceeded TIMEOUT_CYC cycles
//     o_stall      PC unchanged for STALL_CYC samples
//     o_cycles     RUN cycle count (saturating)
//     o_hex_val    decoded digit per channel, 4 bits each
//     o_hex_blank  channel showed all segments off
//     o_hex_err    channel showed an unrecognised pattern
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for i_arm, results cleared
//   RUN     | counting cycles, watching PC for end / timeout / stall
//   CAPTURE | decoding the snapshot taken when the end PC was seen
//   DONE    | results frozen until i_clear
module hex_capture_monitor #(
    parameter int          NUM_HEX     = 8,
    parameter logic [31:0] END_PC      = 32'h0000_01C8,
    parameter int          TIMEOUT_CYC = 1_000_000,
    parameter int          STALL_CYC   = 64,
    parameter int          CNT_W       = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_arm,
    input  logic                 i_clear,
    input  logic [31:0]          i_pc,
    input  logic [NUM_HEX*7-1:0] i_hex,
    output logic [1:0]           o_state,
    output logic                 o_done,
    output logic                 o_pass,
    output logic                 o_timeout,
    output logic                 o_stall,
    output logic [CNT_W-1:0]     o_cycles,
    output logic [NUM_HEX*4-1:0] o_hex_val,
    output logic [NUM_HEX-1:0]   o_hex_blank,
    output logic [NUM_HEX-1:0]   o_hex_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    if (NUM_HEX < 1 || NUM_HEX > 8 || TIMEOUT_CYC < 2 || STALL_CYC < 2) begin : g_param_check
        $error("hex_capture_monitor: illegal parameter value");
    end

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cycles_q, cycles_d;
    logic [NUM_HEX*7-1:0]   snap_q, snap_d;
    logic [NUM_HEX*4-1:0]   val_q, val_d;
    logic [NUM_HEX-1:0]     blank_q, blank_d;
    logic [NUM_HEX-1:0]     err_q, err_d;
    logic                   pass_q, pass_d;
    logic                   timeout_q, timeout_d;
    logic                   stall_hit;

    logic [NUM_HEX*4-1:0]   dec_val;
    logic [NUM_HEX-1:0]     dec_blank;
    logic [NUM_HEX-1:0]     dec_err;

    // Returns {err, blank, digit}.
    function automatic logic [5:0] seg_decode(input logic [6:0] seg);
        logic [5:0] r;
        r = 6'b10_0000;
        case (seg)
            7'h40: r = {2'b00, 4'h0};
            7'h79: r = {2'b00, 4'h1};
            7'h24: r = {2'b00, 4'h2};
            7'h30: r = {2'b00, 4'h3};
            7'h19: r = {2'b00, 4'h4};
            7'h12: r = {2'b00, 4'h5};
            7'h02: r = {2'b00, 4'h6};
            7'h78: r = {2'b00, 4'h7};
            7'h00: r = {2'b00, 4'h8};
            7'h10: r = {2'b00, 4'h9};
            7'h08: r = {2'b00, 4'hA};
            7'h03: r = {2'b00, 4'hB};
            7'h46: r = {2'b00, 4'hC};
            7'h21: r = {2'b00, 4'hD};
            7'h06: r = {2'b00, 4'hE};
            7'h0E: r = {2'b00, 4'hF};
            7'h7F: r = 6'b01_0000;
            default: r = 6'b10_0000;
        endcase
        return r;
    endfunction

    always_comb begin
        dec_val   = '0;
        dec_blank = '0;
        dec_err   = '0;
        for (int k = 0; k < NUM_HEX; k++) begin
            {dec_err[k], dec_blank[k], dec_val[k*4 +: 4]} = seg_decode(snap_q[k*7 +: 7]);
        end
    end

`ifdef HEXMON_STALL_EN
    localparam int SC_W = $clog2(STALL_CYC);

    logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [31:0]     prev_pc_q;
    logic            stall_q, stall_d;

    assign stall_hit = (stall_cnt_q == SC_W'(STALL_CYC - 1));

    // Counter only runs in RUN; it is zero in every other state, so it is
    // already cleared on the edge that enters RUN.
    always_comb begin
        stall_cnt_d = '0;
        if (!i_clear && state_q == ST_RUN && !stall_hit && i_pc == prev_pc_q) begin
            stall_cnt_d = stall_cnt_q + SC_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stall_cnt_q <= '0;
            prev_pc_q   <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            prev_pc_q   <= i_pc;
            stall_q     <= stall_d;
        end
    end

    assign o_stall = stall_q;
`else
    assign stall_hit = 1'b0;
    assign o_stall   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        snap_d    = snap_q;
        val_d     = val_q;
        blank_d   = blank_q;
        err_d     = err_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
`ifdef HEXMON_STALL_EN
        stall_d   = stall_q;
`endif
        if (i_clear || (state_q == ST_IDLE && i_arm)) begin
            // Both leaving to IDLE and entering RUN start from a clean slate.
            state_d   = i_clear ? ST_IDLE : ST_RUN;
            cycles_d  = '0;
            snap_d    = '0;
            val_d     = '0;
            blank_d   = '0;
            err_d     = '0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
`ifdef HEXMON_STALL_EN
            stall_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (cycles_q != {CNT_W{1'b1}}) cycles_d = cycles_q + CNT_W'(1);
                    if (i_pc == END_PC) begin
                        snap_d  = i_hex;
                        state_d = ST_CAPTURE;
                    end else if (cycles_q == TO_LAST) begin
                        // Count stays at TIMEOUT_CYC-1 so it reports the limit.
                        cycles_d  = cycles_q;
                        timeout_d = 1'b1;
                        state_d   = ST_DONE;
                    end else if (stall_hit) begin
`ifdef HEXMON_STALL_EN
                        stall_d = 1'b1;
`endif
                        state_d = ST_DONE;
                    end
                end
                ST_CAPTURE: begin
                    val_d   = dec_val;
                    blank_d = dec_blank;
                    err_d   = dec_err;
                    pass_d  = ~|dec_err;
                    state_d = ST_DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            cycles_q  <= '0;
            snap_q    <= '0;
            val_q     <= '0;
            blank_q   <= '0;
            err_q     <= '0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycles_q  <= cycles_d;
            snap_q    <= snap_d;
            val_q     <= val_d;
            blank_q   <= blank_d;
            err_q     <= err_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_state     = state_q;
    assign o_done      = (state_q == ST_DONE);
    assign o_pass      = pass_q;
    assign o_timeout   = timeout_q;
    assign o_cycles    = cycles_q;
    assign o_hex_val   = val_q;
    assign o_hex_blank = blank_q;
    assign o_hex_err   = err_q;

endmodule

// File: tb/tb_hex_capture_monitor.sv
module tb_hex_capture_monitor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        arm;
    logic        clr;
    logic [31:0] pc;
    logic [55:0] hex;

    logic [1:0]  a_state, b_state;
    logic        a_done, b_done, a_pass, b_pass;
    logic        a_timeout, b_timeout, a_stall, b_stall;
    logic [31:0] a_cycles, b_cycles, a_val, b_val;
    logic [7:0]  a_blank, b_blank, a_err, b_err;

    // dut_a: default parameters; dut_b: short timeout / stall limits.
    hex_capture_monitor dut_a (
        .i_clk(clk), .i_reset(rst_n), .i_arm(arm), .i_clear(clr), .i_pc(pc), .i_hex(hex),
        .o_state(a_state), .o_done(a_done), .o_pass(a_pass), .o_timeout(a_timeout),
        .o_stall(a_stall), .o_cycles(a_cycles), .o_hex_val(a_val),
        .o_hex_blank(a_blank), .o_hex_err(a_err)
    );

    hex_capture_monitor #(.TIMEOUT_CYC(16), .STALL_CYC(8)) dut_b (
        .i_clk(clk), .i_reset(rst_n), .i_arm(arm), .i_clear(clr), .i_pc(pc), .i_hex(hex),
        .o_state(b_state), .o_done(b_done), .o_pass(b_pass), .o_timeout(b_timeout),
        .o_stall(b_stall), .o_cycles(b_cycles), .o_hex_val(b_val),
        .o_hex_blank(b_blank), .o_hex_err(b_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [55:0] pack(input logic [6:0] c7, input logic [6:0] c6,
                                         input logic [6:0] c5, input logic [6:0] c4,
                                         input logic [6:0] c3, input logic [6:0] c2,
                                         input logic [6:0] c1, input logic [6:0] c0);
        return {c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    int n;

    initial begin
        rst_n = 1'b0; arm = 1'b0; clr = 1'b0; pc = '0; hex = '0;

        // Reset state
        #12;
        check("rst_a_state", a_state, 2'd0);
        check("rst_a_done", a_done, 1'b0);
        check("rst_a_cycles", a_cycles, 32'd0);
        check("rst_a_val", a_val, 32'd0);
        check("rst_b_state", b_state, 2'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("idle_hold", a_state, 2'd0);

        // Normal program run to END_PC
        hex = pack(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79);
        pc = 32'h0; arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_state", a_state, 2'd1);
        check("arm_cycles", a_cycles, 32'd0);
        for (int i = 0; i <= 114; i++) begin
            pc = 32'(i * 4);
            tick();
        end
        check("end_capture_state", a_state, 2'd2);
        check("end_capture_done", a_done, 1'b0);
        check("end_capture_cycles", a_cycles, 32'd115);
        pc = 32'h1CC;
        tick();
        check("end_done", a_done, 1'b1);
        check("end_state", a_state, 2'd3);
        check("end_pass", a_pass, 1'b1);
        check("end_val", a_val, 32'h0000_0001);
        check("end_err", a_err, 8'h00);
        check("end_blank", a_blank, 8'h00);
        check("end_timeout", a_timeout, 1'b0);
        check("end_cycles", a_cycles, 32'd115);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_state", a_state, 2'd0);
        check("clr_pass", a_pass, 1'b0);
        check("clr_val", a_val, 32'd0);
        check("clr_b_timeout", b_timeout, 1'b0);
        check("clr_b_cycles", b_cycles, 32'd0);

        // Timeout with PC always moving
        pc = 32'h1000; arm = 1'b1;
        tick();
        arm = 1'b0;
        n = 0;
        while (!b_done && n < 40) begin
            pc = pc + 32'd4;
            tick();
            n++;
        end
        check("to_ticks", 32'(n), 32'd16);
        check("to_flag", b_timeout, 1'b1);
        check("to_pass", b_pass, 1'b0);
        check("to_cycles", b_cycles, 32'd15);
        check("to_stall", b_stall, 1'b0);
        arm = 1'b1;
        tick(); tick();
        arm = 1'b0;
        check("done_hold_state", b_state, 2'd3);
        check("done_hold_cycles", b_cycles, 32'd15);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // PC held constant
        pc = 32'h40;
        tick();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n = 0;
        while (!b_done && n < 40) begin
            tick();
            n++;
        end
`ifdef HEXMON_STALL_EN
        check("stall_ticks", 32'(n), 32'd8);
        check("stall_flag", b_stall, 1'b1);
        check("stall_timeout", b_timeout, 1'b0);
        check("stall_cycles", b_cycles, 32'd8);
`else
        check("stall_ticks", 32'(n), 32'd16);
        check("stall_flag", b_stall, 1'b0);
        check("stall_timeout", b_timeout, 1'b1);
        check("stall_cycles", b_cycles, 32'd15);
`endif
        check("stall_a_run", a_state, 2'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // Blank and unrecognised channels
        hex = pack(7'h46, 7'h30, 7'h55, 7'h08, 7'h7F, 7'h0E, 7'h24, 7'h79);
        pc = 32'h100; arm = 1'b1;
        tick();
        arm = 1'b0;
        pc = 32'h1C8;
        tick();
        check("bad_capture", a_state, 2'd2);
        pc = 32'h1CC;
        tick();
        check("bad_done", a_done, 1'b1);
        check("bad_val", a_val, 32'hC30A_0F21);
        check("bad_blank", a_blank, 8'h08);
        check("bad_err", a_err, 8'h20);
        check("bad_pass", a_pass, 1'b0);
        check("bad_cycles", a_cycles, 32'd1);

        // Clear then re-arm
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("bad_hold_arm", a_state, 2'd3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        hex = pack(7'h21, 7'h03, 7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19);
        pc = 32'h200; arm = 1'b1;
        tick();
        arm = 1'b0;
        check("rearm_state", a_state, 2'd1);
        check("rearm_cycles", a_cycles, 32'd0);
        check("rearm_err", a_err, 8'h00);
        check("rearm_blank", a_blank, 8'h00);
        check("rearm_pass", a_pass, 1'b0);
        check("rearm_val", a_val, 32'd0);
        pc = 32'h204;
        tick();
        check("rearm_cycles1", a_cycles, 32'd1);
        pc = 32'h1C8;
        tick();
        pc = 32'h1CC;
        tick();
        check("rearm_done", a_done, 1'b1);
        check("rearm_val2", a_val, 32'hDB98_7654);
        check("rearm_pass2", a_pass, 1'b1);
        check("rearm_cycles2", a_cycles, 32'd2);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // END_PC on the same cycle the timeout would fire
        hex = pack(7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h40, 7'h06);
        pc = 32'h300; arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 15; i++) begin
            pc = 32'h304 + 32'(i * 4);
            tick();
        end
        check("race_run", b_state, 2'd1);
        check("race_cycles15", b_cycles, 32'd15);
        pc = 32'h1C8;
        tick();
        check("race_capture", b_state, 2'd2);
        check("race_timeout0", b_timeout, 1'b0);
        pc = 32'h400;
        tick();
        check("race_done", b_done, 1'b1);
        check("race_pass", b_pass, 1'b1);
        check("race_timeout", b_timeout, 1'b0);
        check("race_val", b_val, 32'h1111_110E);
        check("race_cycles", b_cycles, 32'd16);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // Asynchronous reset while in CAPTURE
        pc = 32'h500; arm = 1'b1;
        tick();
        arm = 1'b0;
        pc = 32'h1C8;
        tick();
        check("rc_capture", a_state, 2'd2);
        rst_n = 1'b0;
        #1;
        check("rc_state", a_state, 2'd0);
        check("rc_done", a_done, 1'b0);
        check("rc_cycles", a_cycles, 32'd0);
        check("rc_pass", a_pass, 1'b0);
        check("rc_val", a_val, 32'd0);
        check("rc_b_state", b_state, 2'd0);
        tick();
        rst_n = 1'b1;
        pc = 32'h600;
        tick(); tick();
        check("rc_idle_after", a_state, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_capture_monitor.md
HEX_CAPTURE_MONITOR -- requirements
Module: hex_capture_monitor

Interface
REQ-001 SHALL have parameter NUM_HEX, default 8, meaning the number of 7-segment channels monitored (legal 1..8).
REQ-002 SHALL have parameter END_PC, default 32'h0000_01C8, meaning the program-end PC that triggers capture.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1_000_000, meaning the maximum RUN cycles before timeout (legal >=2).
REQ-004 SHALL have parameter STALL_CYC, default 64, meaning the consecutive unchanged-PC cycles that declare a stall (legal >=2).
REQ-005 SHALL have parameter CNT_W, default 32, meaning the cycle counter width.
REQ-006 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port i_reset, input, 1, the reset: asynchronous, active-low.
REQ-008 SHALL have port i_arm, input, 1, the start request sampled in IDLE.
REQ-009 SHALL have port i_clear, input, 1, the synchronous return to IDLE from any state.
REQ-010 SHALL have port i_pc, input, 32, the core PC debug value.
REQ-011 SHALL have port i_hex, input, NUM_HEX*7, the packed active-low segment buses; channel k occupies bits [7k+6:7k], segment a at bit 0.
REQ-012 SHALL have port o_state, output, 2, the FSM state: IDLE=0, RUN=1, CAPTURE=2, DONE=3.
REQ-013 SHALL have port o_done, output, 1, high while in DONE.
REQ-014 SHALL have port o_pass, output, 1, the end PC reached with no decode error.
REQ-015 SHALL have ports o_timeout and o_stall, output, 1 each, the failure causes.
REQ-016 SHALL have port o_cycles, output, CNT_W, the RUN cycle count.
REQ-017 SHALL have port o_hex_val, output, NUM_HEX*4, the decoded digit per channel.
REQ-018 SHALL have ports o_hex_blank and o_hex_err, output, NUM_HEX each, the per-channel blank (7'h7F) and unrecognised-pattern flags.

Function
REQ-019 IDLE SHALL go to RUN on the edge where i_arm=1; entering RUN SHALL zero o_cycles, the stall counter and all result outputs.
REQ-020 RUN SHALL increment o_cycles every cycle, saturating at all-ones.
REQ-021 RUN with i_pc==END_PC SHALL register i_hex into a snapshot and go to CAPTURE.
REQ-022 CAPTURE SHALL decode the snapshot in one cycle and go to DONE, giving o_done one cycle after END_PC is sampled.
REQ-023 Decode SHALL map 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, 7-bit) to digits 0..F; 7F SHALL give value 0 with blank=1; any other pattern SHALL give value 0 with err=1.
REQ-024 o_pass SHALL be set on entering DONE from CAPTURE iff every o_hex_err bit is 0.
REQ-025 RUN SHALL set o_timeout and go to DONE when o_cycles reaches TIMEOUT_CYC-1 without END_PC.
REQ-026 The stall counter SHALL increment when i_pc equals its previous-cycle value and reset to 0 otherwise; reaching STALL_CYC-1 in RUN SHALL set o_stall and go to DONE.
REQ-027 RUN priority SHALL be i_clear > END_PC > timeout > stall for simultaneous events.
REQ-028 DONE SHALL hold all outputs stable and ignore i_arm until i_clear.
REQ-029 i_clear=1 SHALL force IDLE and zero all outputs on the next edge.

Reset
REQ-030 i_reset=0 SHALL immediately force IDLE and drive every output, the snapshot and all counters to 0, including mid-RUN or mid-CAPTURE.
REQ-031 After reset release, the block SHALL stay in IDLE until i_arm=1.

Configuration
REQ-032 With macro HEXMON_STALL_EN defined, stall detection SHALL operate per REQ-026.
REQ-033 Without HEXMON_STALL_EN, the stall counter SHALL be absent and o_stall SHALL be constant 0; only END_PC or timeout SHALL end RUN.

Verification
REQ-034 Arm; PC steps 0,4,...,0x1C8; i_hex all channels 7'h40 except ch0=7'h79 -> DONE one cycle after 0x1C8; o_pass=1; o_hex_val=32'h0000_0001.
REQ-035 TIMEOUT_CYC=16; PC increments forever -> o_timeout=1, o_pass=0, o_cycles=15.
REQ-036 With HEXMON_STALL_EN and STALL_CYC=8, PC held at 0x40 -> o_stall=1 after 8 unchanged samples; without the macro -> o_timeout instead.
REQ-037 END_PC reached with ch3=7'h7F and ch5=7'h55 -> o_hex_blank[3]=1, o_hex_err[5]=1, o_pass=0.
REQ-038 Same cycle END_PC and timeout -> o_pass path taken, o_timeout=0; i_reset low during CAPTURE -> all outputs 0, o_state=0 immediately.
REQ-039 i_clear pulsed in DONE, then re-arm -> o_cycles restarts from 0 and all result flags are 0.
